// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// An entry is one fetched instruction together with its PC and its branch-prediction bit.
package fetch_queue_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int FETCH_WIDTH   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } entry_t;

endpackage

// File: rtl/fetch_queue_compact.sv
// Combinational 4-slot compactor.
// It packs the masked fetch slots toward slot 0, keeping their original order, and counts them.
module ifq_compact
    import fetch_queue_pkg::*;
(
    input  logic   [FETCH_WIDTH-1:0] mask,
    input  entry_t [FETCH_WIDTH-1:0] slot_in,
    output entry_t [FETCH_WIDTH-1:0] slot_out,
    output logic   [2:0]             count
);

    always_comb begin
        slot_out = '0;
        count    = '0;
        // Running count doubles as the write position for the next valid slot.
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (mask[i]) begin
                slot_out[count[1:0]] = slot_in[i];
                count                = count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a circular buffer between the PC generator and decode.
// It accepts up to four instructions per cycle and presents up to four per cycle, oldest first.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    input  logic [FETCH_WIDTH-1:0]       enq_mask,
    input  logic [FETCH_WIDTH-1:0][31:0] pc_in,
    input  logic [FETCH_WIDTH-1:0][31:0] inst_in,
    input  logic [FETCH_WIDTH-1:0]       pred_in,
    output logic                         stall_pc,
    input  logic                         deq_ready,
    output logic [FETCH_WIDTH-1:0]       deq_valid,
    output logic [FETCH_WIDTH-1:0][31:0] pc_out,
    output logic [FETCH_WIDTH-1:0][31:0] inst_out,
    output logic [FETCH_WIDTH-1:0]       pred_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] FW_C    = (AW+1)'(FETCH_WIDTH);

    entry_t              mem [DEPTH];
    logic [AW-1:0]       head, tail;
    logic [AW:0]         count;
    entry_t [FETCH_WIDTH-1:0] slot_in, slot_cmp;
    logic [2:0]          enq_n, deq_n;
    logic                enq_fire, deq_fire;
    logic [AW:0]         enq_add, deq_sub;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            slot_in[i] = '{pc: pc_in[i], inst: inst_in[i], pred: pred_in[i]};
    end

    ifq_compact u_compact (
        .mask     (enq_mask),
        .slot_in  (slot_in),
        .slot_out (slot_cmp),
        .count    (enq_n)
    );

    // The stall decision uses only the registered count, so it does not wait for this cycle's dequeue.
    assign stall_pc = (DEPTH_C - count) < FW_C;
    assign enq_fire = enq_valid && !stall_pc && !flush;
    assign deq_fire = deq_ready && !flush;
    assign deq_n    = (count >= FW_C) ? 3'd4 : count[2:0];
    assign enq_add  = enq_fire ? (AW+1)'(enq_n) : '0;
    assign deq_sub  = deq_fire ? (AW+1)'(deq_n) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + enq_add[AW-1:0];
            head  <= head + deq_sub[AW-1:0];
            count <= count + enq_add - deq_sub;
        end
    end

    // Payload storage has no reset; the valid state is held entirely in head, tail and count.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++)
                if (3'(i) < enq_n)
                    mem[tail + AW'(i)] <= slot_cmp[i];
        end
    end

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_out
        entry_t e;
        assign e            = mem[head + AW'(g)];
        assign deq_valid[g] = count > (AW+1)'(g);
        assign pc_out[g]    = e.pc;
        assign inst_out[g]  = e.inst;
        assign pred_out[g]  = e.pred;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH = 16).
// Every expected value below is worked out by hand from the queue state.
module tb_fetch_queue;

    logic             clk = 0;
    logic             rst;
    logic             flush, enq_valid, deq_ready;
    logic [3:0]       enq_mask, pred_in;
    logic [3:0][31:0] pc_in, inst_in;
    logic             stall_pc;
    logic [3:0]       deq_valid, pred_out;
    logic [3:0][31:0] pc_out, inst_out;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [31:0] B = 32'h2000_0000;

    fetch_queue #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid),
        .enq_mask(enq_mask), .pc_in(pc_in), .inst_in(inst_in), .pred_in(pred_in),
        .stall_pc(stall_pc), .deq_ready(deq_ready), .deq_valid(deq_valid),
        .pc_out(pc_out), .inst_out(inst_out), .pred_out(pred_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive a group whose slots hold base, base+4, base+8, base+12; each instruction word is ~pc.
    task automatic grp(input logic [3:0] m, input logic [31:0] base);
        enq_valid = 1;
        enq_mask  = m;
        for (int i = 0; i < 4; i++) begin
            pc_in[i]   = base + 32'(4 * i);
            inst_in[i] = ~(base + 32'(4 * i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        enq_valid = 0;
        deq_ready = 0;
        flush     = 0;
        enq_mask  = 0;
        pred_in   = 0;
    endtask

    initial begin
        rst = 0; flush = 0; enq_valid = 0; deq_ready = 0;
        enq_mask = 0; pred_in = 0; pc_in = '0; inst_in = '0;
        #3;
        chk("rst_deq_valid", 32'(deq_valid), 32'h0);
        chk("rst_stall", 32'(stall_pc), 32'h0);
        @(negedge clk);
        rst = 1;
        step();

        // Full group, no dequeue.
        grp(4'b1111, 32'h1c00_0000);
        pred_in = 4'b0101;
        step();
        chk("full_deq_valid", 32'(deq_valid), 32'hf);
        chk("full_pc0", pc_out[0], 32'h1c00_0000);
        chk("full_pc3", pc_out[3], 32'h1c00_000c);
        chk("full_inst1", inst_out[1], 32'he3ff_fffb);
        chk("full_pred", 32'(pred_out), 32'h5);
        chk("full_stall", 32'(stall_pc), 32'h0);

        // Three more full groups bring count to 16, so stall_pc rises.
        for (int g = 1; g < 4; g++) begin
            grp(4'b1111, 32'h1c00_0000 + 32'(16 * g));
            step();
        end
        chk("fill_stall", 32'(stall_pc), 32'h1);
        // The fifth group is dropped because the queue is full.
        grp(4'b1111, 32'hdead_0000);
        step();
        chk("over_stall", 32'(stall_pc), 32'h1);
        chk("over_pc0", pc_out[0], 32'h1c00_0000);
        // Drain the queue four entries per cycle; the dropped group must not show up.
        for (int g = 0; g < 4; g++) begin
            chk("drain_pc0", pc_out[0], 32'h1c00_0000 + 32'(16 * g));
            deq_ready = 1;
            step();
        end
        chk("drain_empty", 32'(deq_valid), 32'h0);

        // Sparse mask 1010 compacts slots 1 and 3 into entries 0 and 1.
        grp(4'b1010, 32'h0000_00fc);
        pc_in[1] = 32'h100; pc_in[3] = 32'h108;
        pred_in = 4'b1000;
        deq_ready = 1;      // dequeue while empty does nothing
        step();
        chk("sparse_deq_valid", 32'(deq_valid), 32'h3);
        chk("sparse_pc0", pc_out[0], 32'h100);
        chk("sparse_pc1", pc_out[1], 32'h108);
        chk("sparse_pred", 32'(pred_out[1:0]), 32'h2);
        // A valid group with an all-zero mask changes nothing.
        grp(4'b0000, 32'h3000_0000);
        step();
        chk("zero_mask", 32'(deq_valid), 32'h3);

        // Bring count to 9: 2 + 4 + 3.
        grp(4'b1111, 32'h4000_0000); step();
        grp(4'b0111, 32'h5000_0000); step();
        chk("nine_pc2", pc_out[2], 32'h4000_0000);
        // A flush in the same cycle as an enqueue and a dequeue clears the queue and blocks both.
        grp(4'b1111, 32'h6000_0000);
        deq_ready = 1; flush = 1;
        step();
        chk("flush_deq_valid", 32'(deq_valid), 32'h0);
        chk("flush_stall", 32'(stall_pc), 32'h0);
        step();
        chk("flush_hold", 32'(deq_valid), 32'h0);

        // Move head to 12: enqueue 12 entries, then dequeue all 12.
        for (int g = 0; g < 3; g++) begin grp(4'b1111, 32'h7000_0000); step(); end
        for (int g = 0; g < 3; g++) begin deq_ready = 1; step(); end
        chk("wrap_empty", 32'(deq_valid), 32'h0);
        // 14 entries at indices 12..15 and 0..9, with PCs B+4k for k = 0..13.
        for (int g = 0; g < 3; g++) begin grp(4'b1111, B + 32'(16 * g)); step(); end
        grp(4'b0011, B + 32'd48); step();
        chk("c14_stall", 32'(stall_pc), 32'h1);
        chk("c14_pc0", pc_out[0], B);
        chk("c14_pc3", pc_out[3], B + 32'd12);
        // With count 14, only two slots are free, so stall_pc is high and the 0011 group is not enqueued.
        // The dequeue still removes 4 entries: count becomes 10 and head wraps to 0.
        grp(4'b0011, 32'hbad0_0000);
        deq_ready = 1;
        step();
        chk("wrap_pc0", pc_out[0], B + 32'd16);
        chk("wrap_pc3", pc_out[3], B + 32'd28);
        chk("wrap_stall", 32'(stall_pc), 32'h0);
        deq_ready = 1; step();
        chk("wrap_pc0b", pc_out[0], B + 32'd32);
        deq_ready = 1; step();
        chk("wrap_tail_valid", 32'(deq_valid), 32'h3);
        chk("wrap_tail_pc1", pc_out[1], B + 32'd52);
        deq_ready = 1; step();
        chk("wrap_done", 32'(deq_valid), 32'h0);

        // Asserting reset mid-stream clears the queue at once, without waiting for a clock edge.
        grp(4'b1111, 32'h8000_0000); step();
        #2 rst = 0;
        #1;
        chk("async_rst", 32'(deq_valid), 32'h0);
        #5 rst = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
